// File: rtl/window_buffer_kxk.sv
// rtl/window_buffer_kxk.sv - KxK sliding pixel window with frame position tracking
module window_buffer_kxk #(
  parameter int DATA_WIDTH = 8,
  parameter int K          = 5,
  parameter int COLS       = 640,
  parameter int ROWS       = 480
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         sof_i,
  input  logic [K*DATA_WIDTH-1:0]      col_i,
  output logic [K*K*DATA_WIDTH-1:0]    win_o,
  output logic                         win_valid,
  output logic [$clog2(COLS)-1:0]      col_idx,
  output logic [$clog2(ROWS)-1:0]      row_idx,
  output logic                         eol_o,
  output logic                         eof_o
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          last_col;
  logic          last_row;

  // Position of the column being accepted; sof forces it to the frame origin
  always_comb begin
    cur_col  = col_cnt;
    cur_row  = row_cnt;
    if (sof_i) begin
      cur_col = '0;
      cur_row = '0;
    end
    last_col = (cur_col == CW'(COLS - 1));
    last_row = (cur_row == RW'(ROWS - 1));
  end

  // Counters hold the position the next accepted column will occupy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= last_row ? '0 : cur_row + 1'b1;
      end else begin
        col_cnt <= cur_col + 1'b1;
        row_cnt <= cur_row;
      end
    end
  end

  // Shift window left by one column and insert the new column on the right
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_o <= '0;
    end else if (in_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_o[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] <= win_o[(r*K+c+1)*DATA_WIDTH +: DATA_WIDTH];
        end
        win_o[(r*K+K-1)*DATA_WIDTH +: DATA_WIDTH] <= col_i[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Indices and flags describe the newest column, aligned with win_o
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_idx   <= '0;
      row_idx   <= '0;
      win_valid <= 1'b0;
      eol_o     <= 1'b0;
      eof_o     <= 1'b0;
    end else if (in_valid) begin
      col_idx   <= cur_col;
      row_idx   <= cur_row;
      win_valid <= (cur_col >= CW'(K - 1)) && (cur_row >= RW'(K - 1));
      eol_o     <= last_col;
      eof_o     <= last_col && last_row;
    end else begin
      win_valid <= 1'b0;
      eol_o     <= 1'b0;
      eof_o     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_buffer_kxk.sv
// tb/tb_window_buffer_kxk.sv - self-checking bench for window_buffer_kxk
module tb_window_buffer_kxk;

  localparam int DW   = 8;
  localparam int K    = 3;
  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int K2   = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              sof_i = 1'b0;
  logic [K*DW-1:0]   col_i = '0;
  logic [K*K*DW-1:0] win_o;
  logic              win_valid;
  logic [1:0]        col_idx;
  logic [1:0]        row_idx;
  logic              eol_o;
  logic              eof_o;

  logic                in_valid2 = 1'b0;
  logic                sof2 = 1'b0;
  logic [K2*DW-1:0]    col2 = '0;
  logic [K2*K2*DW-1:0] win2;
  logic                win_valid2;
  logic [2:0]          col_idx2;
  logic [2:0]          row_idx2;
  logic                eol2;
  logic                eof2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [K*DW-1:0]   hist[$];
  int                pos;
  logic [K*K*DW-1:0] e_win;
  logic              e_valid, e_eol, e_eof;
  int                e_col, e_row;

  window_buffer_kxk #(.DATA_WIDTH(DW), .K(K), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sof_i(sof_i), .col_i(col_i),
    .win_o(win_o), .win_valid(win_valid), .col_idx(col_idx), .row_idx(row_idx),
    .eol_o(eol_o), .eof_o(eof_o)
  );

  window_buffer_kxk #(.DATA_WIDTH(DW), .K(K2), .COLS(5), .ROWS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .sof_i(sof2), .col_i(col2),
    .win_o(win2), .win_valid(win_valid2), .col_idx(col_idx2), .row_idx(row_idx2),
    .eol_o(eol2), .eof_o(eof2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [K*DW-1:0] mk(input int n);
    logic [K*DW-1:0] v;
    for (int r = 0; r < K; r++) v[r*DW +: DW] = 8'(r*16 + n);
    return v;
  endfunction

  function automatic logic [K2*DW-1:0] mk5(input int n);
    logic [K2*DW-1:0] v;
    for (int r = 0; r < K2; r++) v[r*DW +: DW] = 8'(r*16 + n);
    return v;
  endfunction

  function automatic logic [DW-1:0] elem(input int r, input int c);
    return win_o[(r*K+c)*DW +: DW];
  endfunction

  // Model: window = last K accepted columns; position = count since frame start
  task automatic model_step(input logic v, input logic s, input logic [K*DW-1:0] c, input logic rn);
    int cc, rr;
    if (!rn) begin
      hist.delete();
      for (int i = 0; i < K; i++) hist.push_back('0);
      pos = 0; e_col = 0; e_row = 0;
      e_valid = 1'b0; e_eol = 1'b0; e_eof = 1'b0;
    end else if (v) begin
      if (s) pos = 0;
      cc = pos % COLS;
      rr = (pos / COLS) % ROWS;
      pos++;
      void'(hist.pop_front());
      hist.push_back(c);
      e_col = cc; e_row = rr;
      e_valid = (cc >= K-1) && (rr >= K-1);
      e_eol = (cc == COLS-1);
      e_eof = e_eol && (rr == ROWS-1);
    end else begin
      e_valid = 1'b0; e_eol = 1'b0; e_eof = 1'b0;
    end
    for (int r = 0; r < K; r++)
      for (int cl = 0; cl < K; cl++)
        e_win[(r*K+cl)*DW +: DW] = hist[cl][r*DW +: DW];
  endtask

  // Drive one cycle, advance the model, then compare every output at negedge
  task automatic cycle(input logic v, input logic s, input logic [K*DW-1:0] c, input logic rn = 1'b1);
    in_valid = v; sof_i = s; col_i = c; rst_n = rn;
    @(posedge clk);
    model_step(v, s, c, rn);
    @(negedge clk);
    chk("win_o", 256'(win_o), 256'(e_win));
    chk("win_valid", 256'(win_valid), 256'(e_valid));
    chk("col_idx", 256'(col_idx), 256'(e_col));
    chk("row_idx", 256'(row_idx), 256'(e_row));
    chk("eol_o", 256'(eol_o), 256'(e_eol));
    chk("eof_o", 256'(eof_o), 256'(e_eof));
  endtask

  // One 12-column frame with literal expectations; optional idle gap after each column
  task automatic frame(input bit gaps);
    for (int n = 0; n < 12; n++) begin
      cycle(1'b1, 1'b0, mk(n));
      chk("lit_valid", 256'(win_valid), 256'(n >= 10));
      chk("lit_eol", 256'(eol_o), 256'(n % 4 == 3));
      chk("lit_eof", 256'(eof_o), 256'(n == 11));
      if (n == 10) begin
        chk("lit_e00", 256'(elem(0, 0)), 256'(8'h08));
        chk("lit_e22", 256'(elem(2, 2)), 256'(8'h2A));
      end
      if (gaps) begin
        cycle(1'b0, 1'b0, K*DW'($urandom));
        chk("gap_flags", 256'({win_valid, eol_o, eof_o}), 256'(0));
      end
    end
  endtask

  initial begin
    int cnt;
    logic [DW-1:0] e44;
    model_step(1'b0, 1'b0, '0, 1'b0);

    // Reset state
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b1, mk(99), 1'b0);
    chk("rst_all", 256'({win_o, win_valid, col_idx, row_idx, eol_o, eof_o}), 256'(0));

    // Continuous frame, then a frame with idle gaps
    frame(1'b0);
    frame(1'b1);

    // sof mid-frame at column n=6
    for (int n = 0; n < 6; n++) cycle(1'b1, 1'b0, mk(n));
    cycle(1'b1, 1'b1, mk(6));
    chk("sof_col", 256'(col_idx), 256'(0));
    chk("sof_row", 256'(row_idx), 256'(0));
    for (int k = 1; k <= 11; k++) begin
      cycle(1'b1, 1'b0, mk(6 + k));
      chk("sof_valid", 256'(win_valid), 256'(k >= 10));
    end

    // Reset mid-frame after n=9, next frame repeats the continuous case
    cycle(1'b0, 1'b0, '0, 1'b0);
    for (int n = 0; n < 10; n++) cycle(1'b1, 1'b0, mk(n));
    cycle(1'b1, 1'b0, mk(10), 1'b0);
    chk("midrst_all", 256'({win_o, win_valid, col_idx, row_idx, eol_o, eof_o}), 256'(0));
    frame(1'b0);

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(3) != 0), ($urandom_range(39) == 0), K*DW'($urandom),
            ($urandom_range(499) != 0));
    end

    // K=5, 5x5 frame on the second instance
    cycle(1'b0, 1'b0, '0, 1'b0);
    cnt = 0;
    e44 = '0;
    for (int n = 0; n < 25; n++) begin
      in_valid2 = 1'b1; sof2 = 1'b0; col2 = mk5(n);
      cycle(1'b0, 1'b0, '0);
      if (win_valid2) begin
        cnt++;
        e44 = win2[(4*K2+4)*DW +: DW];
      end
      if (n == 24) chk("k5_valid_last", 256'(win_valid2), 256'(1));
    end
    in_valid2 = 1'b0;
    cycle(1'b0, 1'b0, '0);
    chk("k5_gap_valid", 256'(win_valid2), 256'(0));
    chk("k5_count", 256'(cnt), 256'(1));
    chk("k5_e44", 256'(e44), 256'(8'd88));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
